// File: rtl/seq_scan_ctrl.sv
// Frame sequencer for a serial "110" detector: serializes W-bit words MSB-first,
// resets the detector at frame start and counts its hits. Optional abort input via SCAN_ABORT_EN.
module seq_scan_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          word_valid,
  input  logic [W-1:0]  word_data,
  input  logic          word_last,
  output logic          word_ready,
  output logic          det_rst,
  output logic          det_bit,
  input  logic          det_hit,
  output logic          busy,
  output logic [CW-1:0] hit_count,
  output logic          frame_done,
  output logic          frame_err
`ifdef SCAN_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam int IW = $clog2(W);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [W-1:0]  sreg_reg, sreg_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          last_reg, last_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;
  logic          in_frame;
  logic          abort_hit;
  logic          at_idx0;

  assign in_frame = (state_reg == CLEAR) || (state_reg == SHIFT) || (state_reg == DRAIN);
  assign at_idx0  = (idx_reg == '0);

`ifdef SCAN_ABORT_EN
  assign abort_hit = abort && in_frame;
`else
  assign abort_hit = 1'b0;
`endif

  // Handshake depends on state/index only; the detector cannot stall, so a missed slot is an underrun.
  assign word_ready = (state_reg == IDLE) ||
                      ((state_reg == SHIFT) && at_idx0 && !last_reg && !abort_hit);
  assign det_rst    = rst || (state_reg == CLEAR);
  assign det_bit    = (state_reg == SHIFT) && sreg_reg[W-1];
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == DONE);
  assign hit_count  = cnt_reg;
  assign frame_err  = err_reg;

  always_comb begin
    state_next = state_reg;
    sreg_next  = sreg_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;

    // Hits seen in DONE belong to the drain bit and are deliberately dropped.
    if (((state_reg == SHIFT) || (state_reg == DRAIN)) && det_hit && (cnt_reg != CNT_MAX))
      cnt_next = cnt_reg + CW'(1);

    case (state_reg)
      IDLE: begin
        if (word_valid) begin
          sreg_next  = word_data;
          last_next  = word_last;
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        idx_next   = IW'(W - 1);
        state_next = SHIFT;
      end
      SHIFT: begin
        if (at_idx0) begin
          if (last_reg) begin
            state_next = DRAIN;
          end else if (word_valid) begin
            sreg_next = word_data;
            last_next = word_last;
            idx_next  = IW'(W - 1);
          end else begin
            err_next   = 1'b1;
            state_next = DRAIN;
          end
        end else begin
          sreg_next = {sreg_reg[W-2:0], 1'b0};
          idx_next  = idx_reg - IW'(1);
        end
      end
      DRAIN: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (abort_hit) begin
      state_next = DONE;
      err_next   = 1'b1;
      cnt_next   = cnt_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sreg_reg  <= '0;
      idx_reg   <= '0;
      last_reg  <= 1'b0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sreg_reg  <= sreg_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

endmodule
